// File: rtl/lane_phase_scheduler.sv
// Lane phase scheduler: serves the lane with the most waiting cars through green -> yellow -> all-red.
// Optional starvation guard is compiled in when STARVATION_GUARD_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | all lights red, picks the next lane on every edge
// ST_GREEN  | active lane green, held GREEN_MIN..GREEN_MAX cycles
// ST_YELLOW | active lane yellow for YELLOW_CYC cycles
// ST_ALLRED | clearance, all red for ALLRED_CYC cycles
module lane_phase_scheduler #(
    parameter int NUM_LANES    = 8,
    parameter int COUNT_W      = 8,
    parameter int GREEN_MIN    = 4,
    parameter int GREEN_MAX    = 16,
    parameter int YELLOW_CYC   = 2,
    parameter int ALLRED_CYC   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_LANES*COUNT_W-1:0]   carCounts,
    output logic [NUM_LANES-1:0]           green,
    output logic [NUM_LANES-1:0]           yellow,
    output logic [$clog2(NUM_LANES)-1:0]   active_lane,
    output logic [1:0]                     phase,
    output logic                           sel_valid
);

    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int T_MAX0 = (GREEN_MAX > YELLOW_CYC) ? GREEN_MAX : YELLOW_CYC;
    localparam int T_MAX  = (T_MAX0 > ALLRED_CYC) ? T_MAX0 : ALLRED_CYC;
    localparam int TMR_W  = $clog2(T_MAX + 1);
    localparam logic [NUM_LANES-1:0] LANE0_HOT = NUM_LANES'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10,
        ST_ALLRED = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_LANES-1:0] green_q, green_d;
    logic [NUM_LANES-1:0] yellow_q, yellow_d;
    logic [LANE_W-1:0]    active_lane_q, active_lane_d;
    logic                 sel_valid_q, sel_valid_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 served_q, served_d;

    logic [COUNT_W-1:0]   cnt [NUM_LANES];
    logic                 others_nz;
    logic                 excl;
    logic [COUNT_W-1:0]   best_cnt;
    logic [LANE_W-1:0]    best_idx;
    logic [LANE_W-1:0]    sel_idx;
    logic                 sel_hit;
    logic [COUNT_W-1:0]   cur_cnt;
    logic                 other_gt;
    logic                 green_exit;

`ifdef STARVATION_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] wait_q [NUM_LANES];
    logic [SW-1:0] wait_d [NUM_LANES];
    logic          starve_found;
    logic          sel_take;
`else
    localparam int unused_starve_limit = STARVE_LIMIT;
`endif

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            cnt[i] = carCounts[i*COUNT_W +: COUNT_W];
        end
    end

    // Lane selection: argmax (lowest index on ties) with the last served lane
    // set aside whenever anyone else is waiting.
    always_comb begin
        others_nz = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (LANE_W'(i) != active_lane_q && cnt[i] != '0) begin
                others_nz = 1'b1;
            end
        end
        excl     = served_q && others_nz;
        best_cnt = '0;
        best_idx = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!(excl && LANE_W'(i) == active_lane_q) && cnt[i] > best_cnt) begin
                best_cnt = cnt[i];
                best_idx = LANE_W'(i);
            end
        end
        sel_idx = best_idx;
        sel_hit = (best_cnt != '0);
`ifdef STARVATION_GUARD_EN
        starve_found = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!starve_found && wait_q[i] >= SW'(STARVE_LIMIT) && cnt[i] != '0) begin
                starve_found = 1'b1;
                sel_idx      = LANE_W'(i);
                sel_hit      = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        cur_cnt  = cnt[active_lane_q];
        other_gt = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (LANE_W'(i) != active_lane_q && cnt[i] > cur_cnt) begin
                other_gt = 1'b1;
            end
        end
        green_exit = (timer_q == TMR_W'(GREEN_MAX)) ||
                     ((timer_q >= TMR_W'(GREEN_MIN)) && ((cur_cnt == '0) || other_gt));
    end

    always_comb begin
        state_d       = state_q;
        green_d       = green_q;
        yellow_d      = yellow_q;
        active_lane_d = active_lane_q;
        sel_valid_d   = 1'b0;
        timer_d       = timer_q;
        served_d      = served_q;
        case (state_q)
            ST_IDLE: begin
                green_d  = '0;
                yellow_d = '0;
                if (sel_hit) begin
                    state_d       = ST_GREEN;
                    green_d       = LANE0_HOT << sel_idx;
                    active_lane_d = sel_idx;
                    sel_valid_d   = 1'b1;
                    timer_d       = TMR_W'(1);
                    served_d      = 1'b1;
                end
            end
            ST_GREEN: begin
                if (green_exit) begin
                    state_d  = ST_YELLOW;
                    green_d  = '0;
                    yellow_d = LANE0_HOT << active_lane_q;
                    timer_d  = TMR_W'(1);
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_YELLOW: begin
                if (timer_q == TMR_W'(YELLOW_CYC)) begin
                    state_d  = ST_ALLRED;
                    yellow_d = '0;
                    timer_d  = TMR_W'(1);
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                green_d  = '0;
                yellow_d = '0;
                if (timer_q == TMR_W'(ALLRED_CYC)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
        endcase
    end

`ifdef STARVATION_GUARD_EN
    // Wait counters age only at selections; an empty lane has nothing to wait for.
    always_comb begin
        sel_take = (state_q == ST_IDLE) && sel_hit;
        for (int i = 0; i < NUM_LANES; i++) begin
            wait_d[i] = wait_q[i];
            if (cnt[i] == '0) begin
                wait_d[i] = '0;
            end else if (sel_take) begin
                if (LANE_W'(i) == sel_idx) begin
                    wait_d[i] = '0;
                end else if (wait_q[i] != {SW{1'b1}}) begin
                    wait_d[i] = wait_q[i] + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (rst) begin
                wait_q[i] <= '0;
            end else begin
                wait_q[i] <= wait_d[i];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            green_q       <= '0;
            yellow_q      <= '0;
            active_lane_q <= '0;
            sel_valid_q   <= 1'b0;
            timer_q       <= '0;
            served_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            green_q       <= green_d;
            yellow_q      <= yellow_d;
            active_lane_q <= active_lane_d;
            sel_valid_q   <= sel_valid_d;
            timer_q       <= timer_d;
            served_q      <= served_d;
        end
    end

    assign green       = green_q;
    assign yellow      = yellow_q;
    assign active_lane = active_lane_q;
    assign phase       = state_q;
    assign sel_valid   = sel_valid_q;

endmodule
